// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: threshold/force-triggered ADC capture into a 256x8 buffer behind an Avalon-MM slave.
//
// Ports
//   main_clk      sole clock, rising edge
//   rst           asynchronous reset, active low
//   sample_data   8-bit ADC sample, qualified by sample_valid
//   sample_valid  one-cycle strobe per sample
//   address       Avalon-MM register address (0 CTRL, 1 THRESH, 2 DECIM, 3 STATUS, 4 RDPTR, 5 DATA, 6 LEN)
//   read, write   Avalon-MM strobes
//   writedata     Avalon-MM write data
//   readdata      registered read data, zero on any cycle after read was low
//   irq           capture-complete interrupt (level)
//   capturing     high while the capture state machine is in CAPTURE
module adc_capture_buffer #(
    parameter int DEPTH = 256
) (
    input  logic       main_clk,
    input  logic       rst,
    input  logic [7:0] sample_data,
    input  logic       sample_valid,
    input  logic [3:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       irq,
    output logic       capturing
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] wptr, wptr_n;
    logic [AW-1:0] rdptr;
    logic [AW-1:0] mem_addr;
    logic [7:0]    dcnt, dcnt_n;
    logic [7:0]    prev, prev_n;
    logic          prev_ok, prev_ok_n;
    logic          force_pend, force_n;
    logic          irq_n;
    logic          mem_we;
    logic [7:0]    thresh, decim, len;
    logic          edge_sel;
    logic [7:0]    rd_mux;
    logic [7:0]    mem [DEPTH];

    logic ctrl_wr, status_wr, arm, abort, force_cmd, keep, crossed;

    assign ctrl_wr   = write && address == 4'd0;
    assign status_wr = write && address == 4'd3;
    assign arm       = ctrl_wr && writedata[0];
    assign force_cmd = ctrl_wr && writedata[1];
    assign abort     = ctrl_wr && writedata[3];
    // The decimation counter sits at zero on every sample that is kept.
    assign keep      = sample_valid && dcnt == 8'd0;
    assign crossed   = edge_sel ? (prev > thresh && sample_data <= thresh)
                                : (prev < thresh && sample_data >= thresh);
    assign capturing = state == CAPTURE;

    always_comb begin
        state_n   = state;
        wptr_n    = wptr;
        prev_n    = prev;
        prev_ok_n = prev_ok;
        force_n   = force_pend;
        irq_n     = irq;
        mem_we    = 1'b0;
        mem_addr  = wptr;
        dcnt_n    = sample_valid ? ((dcnt == decim) ? 8'd0 : dcnt + 8'd1) : dcnt;
        if (abort) begin
            state_n = IDLE;
            irq_n   = 1'b0;
        end else if (arm) begin
            state_n   = ARMED;
            wptr_n    = '0;
            dcnt_n    = 8'd0;
            prev_ok_n = 1'b0;
            force_n   = 1'b0;
            irq_n     = 1'b0;
        end else begin
            if (status_wr) irq_n = 1'b0;
            case (state)
                ARMED: begin
                    if (force_cmd) force_n = 1'b1;
                    if (keep) begin
                        prev_n    = sample_data;
                        prev_ok_n = 1'b1;
                        // The first kept sample after ARM only seeds prev, even with a force pending.
                        if (prev_ok && (force_pend || crossed)) begin
                            mem_we   = 1'b1;
                            mem_addr = '0;
                            wptr_n   = AW'(1);
                            force_n  = 1'b0;
                            state_n  = (len == 8'd0) ? DONE : CAPTURE;
                            if (len == 8'd0) irq_n = 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (keep) begin
                        mem_we = 1'b1;
                        wptr_n = wptr + AW'(1);
                        // wptr equal to LEN means this write is sample number LEN+1.
                        if (wptr == AW'(len)) begin
                            state_n = DONE;
                            irq_n   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = 8'd0;
        case (address)
            4'd0: rd_mux = {5'b0, edge_sel, 2'b0};
            4'd1: rd_mux = thresh;
            4'd2: rd_mux = decim;
            4'd3: rd_mux = {5'b0, irq, state};
            4'd4: rd_mux = 8'(rdptr);
            4'd5: rd_mux = mem[rdptr];
            4'd6: rd_mux = len;
            default: rd_mux = 8'd0;
        endcase
    end

    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wptr       <= '0;
            dcnt       <= 8'd0;
            prev       <= 8'd0;
            prev_ok    <= 1'b0;
            force_pend <= 1'b0;
            irq        <= 1'b0;
            thresh     <= 8'h80;
            decim      <= 8'd0;
            len        <= 8'hFF;
            edge_sel   <= 1'b0;
            rdptr      <= '0;
            readdata   <= 8'd0;
        end else begin
            state      <= state_n;
            wptr       <= wptr_n;
            dcnt       <= dcnt_n;
            prev       <= prev_n;
            prev_ok    <= prev_ok_n;
            force_pend <= force_n;
            irq        <= irq_n;
            readdata   <= read ? rd_mux : 8'd0;
            if (write) begin
                case (address)
                    4'd0: edge_sel <= writedata[2];
                    4'd1: thresh   <= writedata;
                    4'd2: decim    <= writedata;
                    4'd6: len      <= writedata;
                    default: ;
                endcase
            end
            if (write && address == 4'd4) rdptr <= AW'(writedata);
            else if (read && address == 4'd5) rdptr <= rdptr + AW'(1);
        end
    end

    // No reset on the sample memory; a same-edge read sees the old word.
    always_ff @(posedge main_clk) begin
        if (mem_we) mem[mem_addr] <= sample_data;
    end
endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: table-driven register checks, directed capture scenarios and a randomized
// run compared against a transaction-level model of the capture buffer.
module tb_adc_capture_buffer;
    localparam logic [1:0] S_IDLE = 2'd0, S_ARM = 2'd1, S_CAP = 2'd2, S_DONE = 2'd3;

    logic       main_clk;
    logic       rst;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic [3:0] address;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       irq;
    logic       capturing;

    adc_capture_buffer #(.DEPTH(256)) dut (
        .main_clk    (main_clk),
        .rst         (rst),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .irq         (irq),
        .capturing   (capturing)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[$];

    // Behavioural model: register file plus a queue of captured samples.
    logic [1:0] m_state;
    logic [7:0] m_thresh, m_decim, m_len, m_rdptr, m_prev;
    logic       m_edge, m_irq, m_loaded, m_force;
    int         m_n;
    logic [7:0] m_mem [256];
    logic [7:0] cap[$];

    logic [7:0] s35 [7] = '{8'h10, 8'h70, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    logic [7:0] e35 [4] = '{8'h90, 8'hA0, 8'hB0, 8'hC0};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic wr, input logic [3:0] a, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.wr = wr;
        v.addr = a;
        v.data = d;
        v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic mreset();
        m_state = S_IDLE; m_thresh = 8'h80; m_decim = 8'd0; m_len = 8'hFF; m_rdptr = 8'd0;
        m_prev = 8'd0; m_edge = 1'b0; m_irq = 1'b0; m_loaded = 1'b0; m_force = 1'b0; m_n = 0;
        cap.delete();
    endtask

    task automatic mcapture(input logic [7:0] d);
        m_mem[cap.size()] = d;
        cap.push_back(d);
        m_state = S_CAP;
        if (cap.size() == int'(m_len) + 1) begin
            m_state = S_DONE;
            m_irq = 1'b1;
        end
    endtask

    task automatic msample(input logic [7:0] d);
        logic trig;
        if (m_state == S_ARM || m_state == S_CAP) begin
            if (m_n % (int'(m_decim) + 1) == 0) begin
                if (m_state == S_CAP) mcapture(d);
                else if (!m_loaded) begin
                    m_prev = d;
                    m_loaded = 1'b1;
                end else begin
                    trig = m_force || (m_edge ? (m_prev > m_thresh && d <= m_thresh)
                                              : (m_prev < m_thresh && d >= m_thresh));
                    m_prev = d;
                    if (trig) mcapture(d);
                end
            end
            m_n++;
        end
    endtask

    task automatic mwrite(input logic [3:0] a, input logic [7:0] d);
        case (a)
            4'd0: begin
                m_edge = d[2];
                if (d[3]) begin
                    m_state = S_IDLE;
                    m_irq = 1'b0;
                end else if (d[0]) begin
                    m_state = S_ARM; m_n = 0; m_loaded = 1'b0; m_force = 1'b0; m_irq = 1'b0;
                    cap.delete();
                end else if (d[1] && m_state == S_ARM) m_force = 1'b1;
            end
            4'd1: m_thresh = d;
            4'd2: m_decim = d;
            4'd3: m_irq = 1'b0;
            4'd4: m_rdptr = d;
            4'd6: m_len = d;
            default: ;
        endcase
    endtask

    function automatic logic [7:0] mexp(input logic [3:0] a);
        case (a)
            4'd0: return {5'b0, m_edge, 2'b0};
            4'd1: return m_thresh;
            4'd2: return m_decim;
            4'd3: return {5'b0, m_irq, m_state};
            4'd4: return m_rdptr;
            4'd5: return m_mem[m_rdptr];
            4'd6: return m_len;
            default: return 8'd0;
        endcase
    endfunction

    task automatic tick(input logic sv, input logic [7:0] sd, input logic rd, input logic wr,
                        input logic [3:0] a, input logic [7:0] wd);
        @(negedge main_clk);
        sample_valid = sv; sample_data = sd; read = rd; write = wr; address = a; writedata = wd;
        @(posedge main_clk);
        #1;
        sample_valid = 1'b0; read = 1'b0; write = 1'b0; address = 4'd0; writedata = 8'd0;
    endtask

    task automatic idle();
        tick(1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        tick(1'b0, 8'd0, 1'b0, 1'b1, a, d);
        mwrite(a, d);
    endtask

    task automatic do_read_exp(input logic [3:0] a, input logic [7:0] exp, input string name);
        if (a == 4'd5) m_rdptr++;
        tick(1'b0, 8'd0, 1'b1, 1'b0, a, 8'd0);
        check(name, readdata, exp);
    endtask

    task automatic do_read_m(input logic [3:0] a, input string name);
        do_read_exp(a, mexp(a), name);
    endtask

    task automatic do_sample(input logic [7:0] d);
        tick(1'b1, d, 1'b0, 1'b0, 4'd0, 8'd0);
        msample(d);
        check("capturing", 8'(capturing), 8'(m_state == S_CAP));
        check("irq", 8'(irq), 8'(m_irq));
    endtask

    initial begin
        rst = 1'b0; sample_valid = 1'b0; sample_data = 8'd0; read = 1'b0; write = 1'b0;
        address = 4'd0; writedata = 8'd0;
        mreset();
        repeat (2) @(negedge main_clk);
        rst = 1'b1;
        check("reset_readdata", readdata, 8'd0);
        check("reset_capturing", 8'(capturing), 8'd0);

        // Register map: reset values, read-back, unmapped addresses.
        add_vec(0, 4'd0, 8'h00, 8'h00); add_vec(0, 4'd1, 8'h00, 8'h80);
        add_vec(0, 4'd2, 8'h00, 8'h00); add_vec(0, 4'd3, 8'h00, 8'h00);
        add_vec(0, 4'd4, 8'h00, 8'h00); add_vec(0, 4'd6, 8'h00, 8'hFF);
        add_vec(0, 4'd7, 8'h00, 8'h00); add_vec(0, 4'd15, 8'h00, 8'h00);
        add_vec(1, 4'd1, 8'h3C, 8'h00); add_vec(0, 4'd1, 8'h00, 8'h3C);
        add_vec(1, 4'd2, 8'h05, 8'h00); add_vec(0, 4'd2, 8'h00, 8'h05);
        add_vec(1, 4'd6, 8'h0A, 8'h00); add_vec(0, 4'd6, 8'h00, 8'h0A);
        add_vec(1, 4'd0, 8'hF4, 8'h00); add_vec(0, 4'd0, 8'h00, 8'h04);
        add_vec(0, 4'd3, 8'h00, 8'h00);
        add_vec(1, 4'd4, 8'h77, 8'h00); add_vec(0, 4'd4, 8'h00, 8'h77);
        add_vec(1, 4'd9, 8'hAA, 8'h00); add_vec(0, 4'd9, 8'h00, 8'h00);
        add_vec(1, 4'd0, 8'h00, 8'h00); add_vec(0, 4'd0, 8'h00, 8'h00);
        add_vec(1, 4'd1, 8'h80, 8'h00); add_vec(1, 4'd2, 8'h00, 8'h00);
        add_vec(1, 4'd6, 8'hFF, 8'h00); add_vec(1, 4'd4, 8'h00, 8'h00);
        foreach (tbl[i]) begin
            if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data);
            else do_read_exp(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d_addr%0d", i, tbl[i].addr));
        end
        idle();
        check("rd_low_zero", readdata, 8'd0);

        // FORCE outside ARMED is ignored; no crossing keeps ARMED.
        do_write(0, 8'h02);
        do_write(0, 8'h01);
        do_sample(8'h10);
        do_sample(8'h20);
        do_read_exp(3, 8'h01, "force_idle_status");
        do_write(0, 8'h08);
        do_read_exp(3, 8'h00, "abort_armed_status");

        // Rising-edge capture, LEN=3.
        do_write(1, 8'h80); do_write(2, 8'h00); do_write(6, 8'h03); do_write(0, 8'h01);
        for (int i = 0; i < 7; i++) do_sample(s35[i]);
        check("r035_irq", 8'(irq), 8'd1);
        do_read_exp(3, 8'h07, "r035_status");
        do_write(4, 8'h00);
        for (int i = 0; i < 4; i++) do_read_exp(5, e35[i], $sformatf("r035_mem%0d", i));

        // Decimation by 2 with FORCE.
        do_write(2, 8'h01); do_write(6, 8'h01); do_write(0, 8'h01); do_write(0, 8'h02);
        for (int i = 1; i <= 8; i++) do_sample(8'(i));
        do_read_exp(3, 8'h07, "r036_status");
        do_write(4, 8'h00);
        do_read_exp(5, 8'h03, "r036_mem0");
        do_read_exp(5, 8'h05, "r036_mem1");

        // Full-depth capture, then readout wrapping 255 -> 0.
        do_write(2, 8'h00); do_write(6, 8'hFF); do_write(0, 8'h01); do_write(0, 8'h02);
        do_sample(8'hEE);
        for (int i = 0; i < 256; i++) do_sample(8'(i) ^ 8'h5A);
        do_read_exp(3, 8'h07, "r037_status");
        do_write(4, 8'hFF);
        do_read_exp(5, 8'hA5, "r037_mem255");
        do_read_exp(5, 8'h5A, "r037_mem0");
        do_read_exp(4, 8'h01, "r037_rdptr");
        idle();
        check("r037_rd_low", readdata, 8'd0);

        // Memory write and DATA read of the same address on one edge return the old word.
        do_write(6, 8'h02); do_write(0, 8'h01); do_write(0, 8'h02);
        do_sample(8'h00);
        do_sample(8'h11);
        do_write(4, 8'h01);
        tick(1'b1, 8'h22, 1'b1, 1'b0, 4'd5, 8'd0);
        msample(8'h22);
        m_rdptr++;
        check("r031_old_word", readdata, 8'h5B);
        check("r031_capturing", 8'(capturing), 8'd1);
        do_sample(8'h33);
        do_write(4, 8'h01);
        do_read_exp(5, 8'h22, "r031_mem1");
        do_read_exp(5, 8'h33, "r031_mem2");

        // Register write on the same edge as a kept sample uses the old THRESH.
        do_write(1, 8'h80); do_write(6, 8'h00); do_write(0, 8'h01);
        do_sample(8'h70);
        tick(1'b1, 8'h90, 1'b0, 1'b1, 4'd1, 8'hA0);
        msample(8'h90);
        mwrite(4'd1, 8'hA0);
        do_read_exp(3, 8'h07, "r030_status");
        do_read_exp(1, 8'hA0, "r030_thresh");

        // Falling edge, LEN=0: ARMED -> DONE on the trigger.
        do_write(1, 8'h40); do_write(6, 8'h00); do_write(0, 8'h05);
        do_sample(8'h50);
        do_read_exp(3, 8'h01, "r038_armed");
        do_sample(8'h40);
        do_read_exp(3, 8'h07, "r038_status");
        do_write(4, 8'h00);
        do_read_exp(5, 8'h40, "r038_mem0");

        // STATUS write clears irq only.
        do_write(3, 8'h00);
        check("r040_irq", 8'(irq), 8'd0);
        do_read_exp(3, 8'h03, "r040_status");

        // ARM and ABORT together: ABORT wins.
        do_write(0, 8'h09);
        do_read_exp(3, 8'h00, "r039_arm_abort");

        // Reset mid-capture.
        do_write(1, 8'h33); do_write(6, 8'h05); do_write(0, 8'h01); do_write(0, 8'h02);
        do_sample(8'h01);
        do_sample(8'h02);
        check("r039_cap_before", 8'(capturing), 8'd1);
        @(negedge main_clk);
        rst = 1'b0;
        #1;
        check("r039_cap_reset", 8'(capturing), 8'd0);
        check("r039_irq_reset", 8'(irq), 8'd0);
        mreset();
        @(negedge main_clk);
        rst = 1'b1;
        do_read_exp(3, 8'h00, "r039_status");
        do_read_exp(1, 8'h80, "r039_thresh");
        do_sample(8'h00);
        do_sample(8'hFF);
        do_read_exp(3, 8'h00, "r039_stays_idle");

        // Randomized rounds against the model.
        for (int r = 0; r < 30; r++) begin
            logic       ed;
            int         k;
            ed = 1'($urandom_range(0, 1));
            do_write(1, 8'($urandom_range(0, 255)));
            do_write(2, 8'($urandom_range(0, 2)));
            do_write(6, 8'($urandom_range(0, 10)));
            do_write(0, {5'b0, ed, 2'b01});
            if ($urandom_range(0, 1) == 1) do_write(0, {5'b0, ed, 2'b10});
            for (int c = 0; c < 40; c++) begin
                k = int'($urandom_range(0, 19));
                if (k < 14) do_sample(8'($urandom_range(0, 255)));
                else if (k == 14 && r % 5 == 4) do_write(0, {4'b0001, ed, 3'b000});
                else if (k == 15) do_read_m(3, "rnd_status_mid");
                else if (k == 16) do_write(3, 8'h00);
                else idle();
            end
            do_read_m(3, "rnd_status");
            if (m_state == S_DONE) begin
                do_write(4, 8'h00);
                for (int i = 0; i < cap.size(); i++) do_read_m(5, $sformatf("rnd%0d_mem%0d", r, i));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
